montgomery_mult: RTL and testbench

Iterative radix-2 Montgomery multiplier. Computes `result = a·b·R⁻¹ mod modulant`, where R = 2^k is the smallest power of two strictly greater than `modulant`. It sits directly downstream of the R/R² precompute stage and consumes that stage's `R_div_2` (R/2) to set the iteration count and `R_square` to convert operands into the Montgomery domain (`a·R² ·R⁻¹ = a·R`). One multiplication takes k+2 cycles from the accepted `start` to `done`.

---
 rtl/montgomery_mult_if.sv | 31 +++
 rtl/montgomery_mult.sv | 122 ++++++++++++
 tb/tb_montgomery_mult.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/montgomery_mult_if.sv
`default_nettype none
// ============================================================================
// Module   : montgomery_mult_if
// Purpose  : Request/response bundle for the radix-2 Montgomery multiplier.
//            The master drives operands and start. The slave returns the
//            result together with its done/busy status.
// Revision : 1.0 - initial release
// ============================================================================
interface montgomery_mult_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [DATA_WIDTH-1:0] modulant;
    logic [DATA_WIDTH-1:0] r_half;
    logic [DATA_WIDTH-1:0] result;
    logic                  done;
    logic                  busy;

    modport master (
        output start, a, b, modulant, r_half,
        input  result, done, busy
    );

    modport slave (
        input  start, a, b, modulant, r_half,
        output result, done, busy
    );
endinterface
`default_nettype wire

// File: rtl/montgomery_mult.sv
`default_nettype none
// ============================================================================
// Module   : montgomery_mult
// Purpose  : Iterative radix-2 Montgomery multiplier.
//            result = a*b*R^-1 mod N, where R = 2*r_half.
//            The multiplier runs one bit of a per cycle, then does one
//            conditional subtraction. The result is presented one cycle
//            after that, so a multiply takes k+2 cycles from start to done.
// Revision : 1.0 - initial release
// ============================================================================
module montgomery_mult #(
    parameter int DATA_WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    montgomery_mult_if.slave bus
);

    // The accumulator needs two extra bits so that S + b + N (< 3N) fits.
    localparam int c_ACC_W = DATA_WIDTH + 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOP   = 2'd1,
        ST_REDUCE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                 state_q;
    logic [c_ACC_W-1:0]     s_q;
    logic [DATA_WIDTH-1:0]  mask_q;
    logic [DATA_WIDTH-1:0]  a_q;
    logic [DATA_WIDTH-1:0]  b_q;
    logic [DATA_WIDTH-1:0]  n_q;
    logic [DATA_WIDTH-1:0]  rh_q;
    logic [DATA_WIDTH-1:0]  result_q;
    logic                   done_q;
    logic                   busy_q;

    logic [c_ACC_W-1:0]     w_addend;
    logic [c_ACC_W-1:0]     w_t;
    logic [c_ACC_W-1:0]     w_t_odd;
    logic [c_ACC_W-1:0]     w_s_loop;
    logic [c_ACC_W-1:0]     w_n_ext;
    logic [c_ACC_W-1:0]     w_s_red;
    logic                   w_last;
    logic                   w_accept;

    // One Montgomery iteration, the final reduction and the loop-exit test.
    always_comb begin
        w_n_ext  = {2'b00, n_q};
        w_addend = (|(a_q & mask_q)) ? {2'b00, b_q} : '0;
        w_t      = s_q + w_addend;
        w_t_odd  = w_t[0] ? (w_t + w_n_ext) : w_t;
        w_s_loop = {1'b0, w_t_odd[c_ACC_W-1:1]};
        w_s_red  = (s_q >= w_n_ext) ? (s_q - w_n_ext) : s_q;
        // The top-bit test bounds the loop when r_half is not a single set
        // bit, so a malformed r_half can never leave the FSM stuck in LOOP.
        w_last   = (mask_q == rh_q) || mask_q[DATA_WIDTH-1];
        // A new request is taken when idle. It is also taken once a finished
        // result has been shown for at least one cycle.
        w_accept = bus.start && ((state_q == ST_IDLE) ||
                                 ((state_q == ST_DONE) && done_q));
    end

    // Control FSM with registered outputs and the datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            s_q      <= '0;
            mask_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            rh_q     <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else if (w_accept) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            n_q     <= bus.modulant;
            rh_q    <= bus.r_half;
            s_q     <= '0;
            mask_q  <= {{(DATA_WIDTH-1){1'b0}}, 1'b1};
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= (bus.r_half == '0) ? ST_REDUCE : ST_LOOP;
        end else begin
            case (state_q)
                ST_LOOP: begin
                    s_q <= w_s_loop;
                    if (w_last) begin
                        state_q <= ST_REDUCE;
                    end else begin
                        mask_q <= mask_q << 1;
                    end
                end
                ST_REDUCE: begin
                    s_q     <= w_s_red;
                    busy_q  <= 1'b0;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    if (!done_q) begin
                        result_q <= s_q[DATA_WIDTH-1:0];
                        done_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.done   = done_q;
    assign bus.busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_montgomery_mult.sv
`default_nettype none
// ============================================================================
// Module   : tb_montgomery_mult
// Purpose  : Self-checking bench for montgomery_mult. A reference model
//            works out the expected done/busy/result timeline from the
//            mathematical definition. A compare process checks the DUT
//            against that model on every cycle. Directed tests add
//            literal latency and result checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_montgomery_mult;

    localparam int DW = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    montgomery_mult_if #(.DATA_WIDTH(DW)) bus ();

    montgomery_mult #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: the x in [0,N) with x*R == a*b (mod N), where R = 2*r_half.
    function automatic longint mont_ref(input longint a, input longint b,
                                        input longint n, input longint rh);
        longint r;
        longint target;
        if (rh == 0) return 0;
        r      = 2 * rh;
        target = (a * b) % n;
        for (longint x = 0; x < n; x++) begin
            if (((x * r) % n) == target) return x;
        end
        return -1;
    endfunction

    // Cycles from the accepting edge to done: k iterations + reduce + present.
    function automatic int op_latency(input int rh);
        if (rh == 0) return 2;
        return $clog2(rh) + 1 + 2;
    endfunction

    // Behavioural timeline model.
    logic   m_run       = 1'b0;
    int     m_cnt       = 0;
    logic   m_done      = 1'b0;
    logic   m_res_known = 1'b0;
    longint m_result    = 0;
    longint m_exp       = 0;
    logic   cmp_en      = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_run       = 1'b0;
            m_cnt       = 0;
            m_done      = 1'b0;
            m_result    = 0;
            m_res_known = 1'b1;
        end else if (bus.start && !m_run) begin
            m_run       = 1'b1;
            m_cnt       = op_latency(int'(bus.r_half));
            m_done      = 1'b0;
            m_res_known = 1'b0;
            m_exp       = mont_ref(longint'(bus.a), longint'(bus.b),
                                   longint'(bus.modulant), longint'(bus.r_half));
        end else if (m_run) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_run       = 1'b0;
                m_done      = 1'b1;
                m_result    = m_exp;
                m_res_known = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("cyc_done", longint'(bus.done), longint'(m_done));
                check("cyc_busy", longint'(bus.busy), longint'(m_run && (m_cnt >= 2)));
                if (m_res_known) check("cyc_result", longint'(bus.result), m_result);
            end
        end
    end

    // Issue an operation and measure the cycles to done and the busy cycles.
    task automatic run_op(input int a, input int b, input int n, input int rh,
                          output int lat, output int busy_cycles);
        @(negedge clk);
        bus.a        = DW'(a);
        bus.b        = DW'(b);
        bus.modulant = DW'(n);
        bus.r_half   = DW'(rh);
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        lat          = 0;
        busy_cycles  = bus.busy ? 1 : 0;
        while (!bus.done && lat < 200) begin
            @(negedge clk);
            lat++;
            if (bus.busy) busy_cycles++;
        end
        if (lat >= 200) check("timeout_done", 0, 1);
    endtask

    int lat;
    int bc;

    initial begin
        bus.start    = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.modulant = 8'd13;
        bus.r_half   = 8'd8;

        // Pin the reference model itself with hand-derived values.
        check("ref_5x7_n13",     mont_ref(5, 7, 13, 8), 3);
        check("ref_5x9_n13",     mont_ref(5, 9, 13, 8), 2);
        check("ref_14x14_n15",   mont_ref(14, 14, 15, 8), 1);
        check("ref_254sq_n255",  mont_ref(254, 254, 255, 128), 1);

        repeat (2) @(negedge clk);
        reset  = 1'b0;
        cmp_en = 1'b1;
        check("rst_result", longint'(bus.result), 0);
        check("rst_done",   longint'(bus.done), 0);
        check("rst_busy",   longint'(bus.busy), 0);

        // Basic product.
        run_op(5, 7, 13, 8, lat, bc);
        check("lat_5x7", lat, 6);
        check("busy_5x7", bc, 5);
        check("res_5x7", longint'(bus.result), 3);

        // Conversion into the Montgomery domain with R^2 mod N.
        run_op(5, 9, 13, 8, lat, bc);
        check("res_5x9", longint'(bus.result), 2);

        // The final subtraction is needed.
        run_op(14, 14, 15, 8, lat, bc);
        check("res_14x14", longint'(bus.result), 1);

        // Full-width modulus.
        run_op(254, 254, 255, 128, lat, bc);
        check("lat_254sq", lat, 10);
        check("res_254sq", longint'(bus.result), 1);

        // A start pulse during LOOP with a different a is ignored.
        @(negedge clk);
        bus.a = 8'd5; bus.b = 8'd7; bus.modulant = 8'd13; bus.r_half = 8'd8;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.a = 8'd1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("ignored_start_res", longint'(bus.result), 3);

        // A reset in the middle of LOOP aborts without a done.
        @(negedge clk);
        bus.a = 8'd5; bus.b = 8'd7;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy",   longint'(bus.busy), 0);
        check("abort_done",   longint'(bus.done), 0);
        check("abort_result", longint'(bus.result), 0);
        bc = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) bc++;
        end
        check("abort_no_done", bc, 0);

        // Start held high: the result is restarted right after it is shown.
        run_op(5, 9, 13, 8, lat, bc);
        bus.start = 1'b1;
        check("b2b_first_res", longint'(bus.result), 2);
        @(negedge clk);
        check("b2b_done_drop", longint'(bus.done), 0);
        lat = 0;
        while (!bus.done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        check("b2b_lat", lat, 6);
        check("b2b_res", longint'(bus.result), 2);

        // With r_half = 0, LOOP is skipped.
        run_op(5, 9, 13, 0, lat, bc);
        check("rh0_lat", lat, 2);
        check("rh0_res", longint'(bus.result), 0);

        repeat (3) @(negedge clk);
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
